// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 channel multiplexer with valid/ready handshake.
// Channels are selected directly from sel, or by an auto-scan pointer that walks every channel in turn.
module mux_nto1_pipe #(
  parameter int N     = 16,
  parameter int W     = 8,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*W-1:0]     data_in,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;

  logic [SEL_W-1:0] eff_sel;
  logic [W-1:0]     ch_data;
  logic             sel_err;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign eff_sel  = mode ? scan_ptr_q : sel;
  assign sel_err  = (32'(eff_sel) >= N);

  // An out-of-range select matches no channel, so it yields zero data.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N; k++) begin
      if (eff_sel == SEL_W'(k)) ch_data = data_in[k*W +: W];
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = ch_data;
      out_sel_d   = eff_sel;
      out_err_d   = sel_err;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // The pointer is parked at 0 in direct mode so each new scan starts at channel 0.
  always_comb begin
    scan_ptr_d = scan_ptr_q;
    if (!mode) begin
      scan_ptr_d = '0;
    end else if (accept) begin
      if (scan_ptr_q == SEL_W'(N-1)) scan_ptr_d = '0;
      else                           scan_ptr_d = scan_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      scan_ptr_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      scan_ptr_q  <= scan_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: a 16-channel instance for the main flow and a
// 12-channel instance for out-of-range selects; channel k carries 8'h10+k.
module tb_mux_nto1_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-channel instance
  logic [16*8-1:0] a_data;
  logic [3:0]      a_sel;
  logic            a_mode, a_in_valid, a_in_ready, a_out_ready;
  logic [7:0]      a_out_data;
  logic [3:0]      a_out_sel;
  logic            a_out_err, a_out_valid;

  // 12-channel instance
  logic [12*8-1:0] b_data;
  logic [3:0]      b_sel;
  logic            b_mode, b_in_valid, b_in_ready, b_out_ready;
  logic [7:0]      b_out_data;
  logic [3:0]      b_out_sel;
  logic            b_out_err, b_out_valid;

  mux_nto1_pipe #(.N(16), .W(8), .SEL_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data), .sel(a_sel), .mode(a_mode),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mux_nto1_pipe #(.N(12), .W(8), .SEL_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .sel(b_sel), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_a(input logic [7:0] base);
    for (int k = 0; k < 16; k++) a_data[k*8 +: 8] = base + 8'(k);
  endtask

  initial begin
    rst_n = 1'b0;
    fill_a(8'h10);
    for (int k = 0; k < 12; k++) b_data[k*8 +: 8] = 8'h10 + 8'(k);
    a_sel = 4'd0; a_mode = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_sel = 4'd0; b_mode = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_data",  a_out_data,  8'h00);
    check("rst_sel",   a_out_sel,   4'd0);
    check("rst_err",   a_out_err,   1'b0);
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_ready", a_in_ready,  1'b1);
    rst_n = 1'b1;
    step();

    // direct select, back-to-back, then drain
    a_sel = 4'd5; a_in_valid = 1'b1;
    step();
    check("dir5_data",  a_out_data,  8'h15);
    check("dir5_sel",   a_out_sel,   4'd5);
    check("dir5_valid", a_out_valid, 1'b1);
    check("dir5_err",   a_out_err,   1'b0);
    a_sel = 4'd15;
    step();
    check("dir15_data",  a_out_data,  8'h1F);
    check("dir15_valid", a_out_valid, 1'b1);
    a_in_valid = 1'b0;
    step();
    check("drain_valid", a_out_valid, 1'b0);
    check("drain_hold",  a_out_data,  8'h1F);

    // auto-scan with wrap
    a_mode = 1'b1; a_in_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      check($sformatf("scan%0d_sel", i),  a_out_sel,  32'(i % 16));
      check($sformatf("scan%0d_data", i), a_out_data, 32'(8'h10 + 8'(i % 16)));
    end

    // back-pressure
    a_mode = 1'b0; a_sel = 4'd3;
    step();
    check("bp_load", a_out_data, 8'h13);
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_sel = 4'(8 + i);
      fill_a(8'hA0 + 8'(i * 16));
      #1;
      check($sformatf("bp%0d_inrdy", i), a_in_ready, 1'b0);
      step();
      check($sformatf("bp%0d_data", i),  a_out_data,  8'h13);
      check($sformatf("bp%0d_sel", i),   a_out_sel,   4'd3);
      check($sformatf("bp%0d_valid", i), a_out_valid, 1'b1);
    end
    fill_a(8'h10);
    a_out_ready = 1'b1; a_sel = 4'd7;
    #1;
    check("bp_release_inrdy", a_in_ready, 1'b1);
    step();
    check("bp_release_data", a_out_data, 8'h17);
    check("bp_release_sel",  a_out_sel,  4'd7);

    // mode switch
    a_mode = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("ms_scan4_sel", a_out_sel, 4'd4);
    a_mode = 1'b0; a_sel = 4'd9;
    step();
    check("ms_dir9_sel",  a_out_sel,  4'd9);
    check("ms_dir9_data", a_out_data, 8'h19);
    a_mode = 1'b1;
    step();
    check("ms_restart_sel",  a_out_sel,  4'd0);
    check("ms_restart_data", a_out_data, 8'h10);

    // reset mid-stream with scan_ptr at 6
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_sel",   a_out_sel,   4'd5);
    check("pre_rst_valid", a_out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data",  a_out_data,  8'h00);
    check("mid_rst_sel",   a_out_sel,   4'd0);
    check("mid_rst_err",   a_out_err,   1'b0);
    check("mid_rst_valid", a_out_valid, 1'b0);
    check("mid_rst_inrdy", a_in_ready,  1'b1);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_sel",  a_out_sel,  4'd0);
    check("post_rst_data", a_out_data, 8'h10);
    a_in_valid = 1'b0;

    // out of range on the 12-channel instance
    b_sel = 4'd13; b_in_valid = 1'b1;
    step();
    check("oor_data",  b_out_data,  8'h00);
    check("oor_err",   b_out_err,   1'b1);
    check("oor_sel",   b_out_sel,   4'd13);
    check("oor_valid", b_out_valid, 1'b1);
    b_sel = 4'd2;
    step();
    check("inr_err",  b_out_err,  1'b0);
    check("inr_data", b_out_data, 8'h12);
    b_sel = 4'd11;
    step();
    check("edge11_err",  b_out_err,  1'b0);
    check("edge11_data", b_out_data, 8'h1B);
    b_sel = 4'd12;
    step();
    check("edge12_err",  b_out_err,  1'b1);
    check("edge12_data", b_out_data, 8'h00);
    b_in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
